// File: rtl/store_access_ctrl.sv
// store_access_ctrl: sequences MIPS stores (sb, sh, sw, swl, swr) onto a
// word-only data memory. Partial-word stores read the addressed word,
// merge the new bytes and write it back. A full-word sw writes directly.
// Byte lanes are big-endian: lane 0 is bits [31:24], lane 3 is bits [7:0].
//
// Handshakes:
//   st_req/st_done: st_req is sampled only in IDLE. Every accepted request
//   ends with exactly one st_done pulse, and st_err rides on it for failures.
//   mem_req/mem_ack: mem_req is held, with mem_addr/mem_we/mem_wdata stable,
//   until a one-cycle mem_ack arrives or the wait times out. mem_ack is
//   ignored while mem_req is low.
module store_access_ctrl #(
    parameter int TIMEOUT = 255
) (
    input  logic        clk,
    input  logic        reset,
    input  logic        st_req,
    input  logic [5:0]  st_op,
    input  logic [31:0] st_addr,
    input  logic [31:0] st_data,
    output logic        st_busy,
    output logic        st_done,
    output logic        st_err,
    output logic        mem_req,
    output logic        mem_we,
    output logic [31:0] mem_addr,
    output logic [31:0] mem_wdata,
    input  logic [31:0] mem_rdata,
    input  logic        mem_ack,
    output logic [2:0]  state_dbg
);

    localparam logic [5:0] OP_SB  = 6'b101000;
    localparam logic [5:0] OP_SH  = 6'b101001;
    localparam logic [5:0] OP_SWL = 6'b101010;
    localparam logic [5:0] OP_SW  = 6'b101011;
    localparam logic [5:0] OP_SWR = 6'b101110;

    // Last count value that still waits for an ack.
    localparam logic [7:0] TMO_LAST = 8'(TIMEOUT - 1);

    typedef enum logic [2:0] {
        S_IDLE  = 3'd0,
        S_READ  = 3'd1,
        S_WRITE = 3'd2,
        S_DONE  = 3'd3,
        S_ERR   = 3'd4
    } state_t;

    state_t      state;
    state_t      next_state;
    logic [5:0]  op_q;
    logic [31:0] addr_q;
    logic [31:0] data_q;
    logic [31:0] old_q;
    logic [7:0]  cnt;
    logic        timed_out;
    logic        req_bad;
    logic [1:0]  k;
    logic [3:0]  lane_mask;
    logic [31:0] byte_mask;
    logic [31:0] aligned;
    logic [31:0] old_word;
    logic [31:0] merged;

    // Decode errors: unknown opcodes, sh on an odd byte, sw off a word boundary.
    function automatic logic is_bad(input logic [5:0] op, input logic [1:0] lo);
        logic bad;
        case (op)
            OP_SB, OP_SWL, OP_SWR: bad = 1'b0;
            OP_SH:                 bad = lo[0];
            OP_SW:                 bad = (lo != 2'b00);
            default:               bad = 1'b1;
        endcase
        return bad;
    endfunction

    assign req_bad   = is_bad(st_op, st_addr[1:0]);
    assign timed_out = (cnt == TMO_LAST) && !mem_ack;

    // State register.
    always_ff @(posedge clk or posedge reset) begin
        if (reset) state <= S_IDLE;
        else       state <= next_state;
    end

    // Next-state logic; an ack in the final waiting cycle beats the timeout.
    always_comb begin
        next_state = state;
        case (state)
            S_IDLE: begin
                if (st_req) begin
                    if (req_bad)            next_state = S_ERR;
                    else if (st_op == OP_SW) next_state = S_WRITE;
                    else                     next_state = S_READ;
                end
            end
            S_READ: begin
                if (mem_ack)        next_state = S_WRITE;
                else if (timed_out) next_state = S_ERR;
            end
            S_WRITE: begin
                if (mem_ack)        next_state = S_DONE;
                else if (timed_out) next_state = S_ERR;
            end
            S_DONE:  next_state = S_IDLE;
            S_ERR:   next_state = S_IDLE;
            default: next_state = S_IDLE;
        endcase
    end

    // Output decode: everything is a function of the current state.
    always_comb begin
        st_busy   = (state != S_IDLE);
        st_done   = 1'b0;
        st_err    = 1'b0;
        mem_req   = 1'b0;
        mem_we    = 1'b0;
        mem_wdata = 32'd0;
        case (state)
            S_READ: mem_req = 1'b1;
            S_WRITE: begin
                mem_req   = 1'b1;
                mem_we    = 1'b1;
                mem_wdata = merged;
            end
            S_DONE: st_done = 1'b1;
            S_ERR: begin
                st_done = 1'b1;
                st_err  = 1'b1;
            end
            default: ;
        endcase
    end

    assign mem_addr  = {addr_q[31:2], 2'b00};
    assign state_dbg = state;

    // Latch the request once in IDLE so it cannot move during a transaction.
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            op_q   <= 6'd0;
            addr_q <= 32'd0;
            data_q <= 32'd0;
        end else if (state == S_IDLE && st_req) begin
            op_q   <= st_op;
            addr_q <= st_addr;
            data_q <= st_data;
        end
    end

    // Capture the old memory word when the read is acknowledged.
    always_ff @(posedge clk or posedge reset) begin
        if (reset)                          old_q <= 32'd0;
        else if (state == S_READ && mem_ack) old_q <= mem_rdata;
    end

    // Wait counter: cleared on every state change, counts unacked cycles.
    always_ff @(posedge clk or posedge reset) begin
        if (reset)                                      cnt <= 8'd0;
        else if (next_state != state)                   cnt <= 8'd0;
        else if (state == S_READ || state == S_WRITE)   cnt <= cnt + 8'd1;
    end

    // Lane placement and byte mask. lane_mask[3] is lane 0 (bits 31:24).
    always_comb begin
        k = addr_q[1:0];
        case (op_q)
            OP_SB: begin
                aligned   = {4{data_q[7:0]}};
                lane_mask = 4'b1000 >> k;
            end
            OP_SH: begin
                aligned   = {2{data_q[15:0]}};
                lane_mask = addr_q[1] ? 4'b0011 : 4'b1100;
            end
            OP_SWL: begin
                // Leftmost bytes of Rt fill lanes k..3.
                aligned   = data_q >> {k, 3'b000};
                lane_mask = 4'b1111 >> k;
            end
            OP_SWR: begin
                // Rightmost bytes of Rt fill lanes 0..k.
                aligned   = data_q << {(2'd3 - k), 3'b000};
                lane_mask = 4'b1111 << (2'd3 - k);
            end
            default: begin
                aligned   = data_q;
                lane_mask = 4'b1111;
            end
        endcase
    end

    // Read-modify-write merge; sw has no old word.
    always_comb begin
        byte_mask = {{8{lane_mask[3]}}, {8{lane_mask[2]}},
                     {8{lane_mask[1]}}, {8{lane_mask[0]}}};
        old_word  = (op_q == OP_SW) ? 32'd0 : old_q;
        merged    = (old_word & ~byte_mask) | (aligned & byte_mask);
    end

endmodule

// File: tb/tb_store_access_ctrl.sv
// Bench for store_access_ctrl: a driver walks directed store transactions,
// a byte-lane model predicts write data, and one compare process checks the
// DUT against the expected per-cycle timeline.
module tb_store_access_ctrl;

    localparam int TMO = 4;

    localparam logic [5:0] OP_SB  = 6'b101000;
    localparam logic [5:0] OP_SH  = 6'b101001;
    localparam logic [5:0] OP_SWL = 6'b101010;
    localparam logic [5:0] OP_SW  = 6'b101011;
    localparam logic [5:0] OP_SWR = 6'b101110;
    localparam logic [5:0] OP_LW  = 6'b100011;

    logic        clk;
    logic        reset;
    logic        st_req;
    logic [5:0]  st_op;
    logic [31:0] st_addr;
    logic [31:0] st_data;
    logic        st_busy;
    logic        st_done;
    logic        st_err;
    logic        mem_req;
    logic        mem_we;
    logic [31:0] mem_addr;
    logic [31:0] mem_wdata;
    logic [31:0] mem_rdata;
    logic        mem_ack;
    logic [2:0]  state_dbg;

    typedef struct packed {
        logic        busy;
        logic        done;
        logic        err;
        logic        req;
        logic        we;
        logic        chk_wdata;
        logic [31:0] addr;
        logic [31:0] wdata;
    } exp_t;

    exp_t exp_q[$];
    int   n_checks = 0;
    int   n_fail   = 0;

    store_access_ctrl #(.TIMEOUT(TMO)) dut (
        .clk       (clk),
        .reset     (reset),
        .st_req    (st_req),
        .st_op     (st_op),
        .st_addr   (st_addr),
        .st_data   (st_data),
        .st_busy   (st_busy),
        .st_done   (st_done),
        .st_err    (st_err),
        .mem_req   (mem_req),
        .mem_we    (mem_we),
        .mem_addr  (mem_addr),
        .mem_wdata (mem_wdata),
        .mem_rdata (mem_rdata),
        .mem_ack   (mem_ack),
        .state_dbg (state_dbg)
    );

    // Clock and reset
    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_checks++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got 0x%08h expected 0x%08h at %0t", name, act, exp, $time);
        end
    endtask

    // Model: new word from old word, built lane by lane from the store rules.
    function automatic logic [31:0] model_write(input logic [5:0] op, input logic [31:0] addr,
                                                input logic [31:0] data, input logic [31:0] old);
        logic [7:0] lane [4];
        logic [7:0] db [4];
        int kk;
        int b;
        kk = int'(addr[1:0]);
        for (int i = 0; i < 4; i++) begin
            lane[i] = old[31 - 8*i -: 8];
            db[i]   = data[31 - 8*i -: 8];
        end
        case (op)
            OP_SB: lane[kk] = db[3];
            OP_SH: begin
                b = 2 * int'(addr[1]);
                lane[b]     = db[2];
                lane[b + 1] = db[3];
            end
            OP_SWL: for (int j = 0; j <= 3 - kk; j++) lane[kk + j] = db[j];
            OP_SWR: for (int j = 0; j <= kk; j++) lane[kk - j] = db[3 - j];
            default: for (int i = 0; i < 4; i++) lane[i] = db[i];
        endcase
        return {lane[0], lane[1], lane[2], lane[3]};
    endfunction

    function automatic logic model_err(input logic [5:0] op, input logic [31:0] addr);
        if (op == OP_SB || op == OP_SWL || op == OP_SWR) return 1'b0;
        if (op == OP_SH) return addr[0];
        if (op == OP_SW) return addr[1:0] != 2'b00;
        return 1'b1;
    endfunction

    function automatic exp_t mk(input logic busy, input logic done, input logic err,
                                input logic req, input logic we, input logic chkw,
                                input logic [31:0] addr, input logic [31:0] wdata);
        exp_t e;
        e.busy = busy; e.done = done; e.err = err; e.req = req; e.we = we;
        e.chk_wdata = chkw; e.addr = addr; e.wdata = wdata;
        return e;
    endfunction

    // Scoreboard compare: one expected entry per clock cycle, sampled mid-cycle.
    always @(negedge clk) begin
        exp_t e;
        if (exp_q.size() > 0) begin
            e = exp_q.pop_front();
            check("st_busy", 32'(st_busy), 32'(e.busy));
            check("st_done", 32'(st_done), 32'(e.done));
            check("st_err",  32'(st_err),  32'(e.err));
            check("mem_req", 32'(mem_req), 32'(e.req));
            check("mem_we",  32'(mem_we),  32'(e.we));
            if (e.req)       check("mem_addr",  mem_addr,  e.addr);
            if (e.chk_wdata) check("mem_wdata", mem_wdata, e.wdata);
        end
    end

    // Driver: one cycle of inputs plus its expected outputs.
    task automatic cyc(input exp_t e, input logic ack, input logic [31:0] rdata, input logic noise);
        @(posedge clk); #1;
        mem_ack   = ack;
        mem_rdata = rdata;
        if (noise) begin
            st_req  = 1'b1;
            st_op   = 6'($urandom_range(0, 63));
            st_addr = $urandom;
            st_data = $urandom;
        end else begin
            st_req = 1'b0;
        end
        exp_q.push_back(e);
    endtask

    // Driver: full store. Delays are unacked cycles before ack; >= TMO never acks.
    task automatic run_store(input logic [5:0] op, input logic [31:0] addr, input logic [31:0] data,
                             input logic [31:0] old, input int rd_delay, input int wr_delay,
                             input logic noise);
        logic [31:0] waddr;
        logic [31:0] wexp;
        logic        acked;
        waddr = {addr[31:2], 2'b00};
        wexp  = (op == OP_SW) ? data : model_write(op, addr, data, old);
        @(posedge clk); #1;
        st_req = 1'b1; st_op = op; st_addr = addr; st_data = data;
        mem_ack = noise; mem_rdata = 32'd0;
        exp_q.push_back(mk(0, 0, 0, 0, 0, 0, 0, 0));
        if (model_err(op, addr)) begin
            cyc(mk(1, 1, 1, 0, 0, 0, 0, 0), noise, 32'd0, noise);
            cyc(mk(0, 0, 0, 0, 0, 0, 0, 0), 1'b0, 32'd0, 1'b0);
            return;
        end
        if (op != OP_SW) begin
            acked = 1'b0;
            for (int i = 0; i < TMO && !acked; i++) begin
                acked = (i == rd_delay);
                cyc(mk(1, 0, 0, 1, 0, 0, waddr, 0), acked, acked ? old : $urandom, noise);
            end
            if (!acked) begin
                cyc(mk(1, 1, 1, 0, 0, 0, 0, 0), noise, 32'd0, noise);
                cyc(mk(0, 0, 0, 0, 0, 0, 0, 0), 1'b0, 32'd0, 1'b0);
                return;
            end
        end
        acked = 1'b0;
        for (int i = 0; i < TMO && !acked; i++) begin
            acked = (i == wr_delay);
            cyc(mk(1, 0, 0, 1, 1, 1, waddr, wexp), acked, $urandom, noise);
        end
        if (!acked) cyc(mk(1, 1, 1, 0, 0, 0, 0, 0), noise, 32'd0, noise);
        else        cyc(mk(1, 1, 0, 0, 0, 0, 0, 0), noise, 32'd0, noise);
        cyc(mk(0, 0, 0, 0, 0, 0, 0, 0), 1'b0, 32'd0, 1'b0);
    endtask

    initial begin
        reset = 1'b1; st_req = 1'b0; st_op = 6'd0; st_addr = 32'd0; st_data = 32'd0;
        mem_rdata = 32'd0; mem_ack = 1'b0;

        // Model pins, hand computed.
        check("pin_sb",   model_write(OP_SB,  32'h203, 32'h000000AB, 32'hFFFFFFFF), 32'hFFFFFFAB);
        check("pin_swl",  model_write(OP_SWL, 32'h1,   32'hA1B2C3D4, 32'h55667788), 32'h55A1B2C3);
        check("pin_swr",  model_write(OP_SWR, 32'h1,   32'hA1B2C3D4, 32'h55667788), 32'hC3D47788);
        check("pin_sh",   model_write(OP_SH,  32'h2,   32'h00001234, 32'hAABBCCDD), 32'hAABB1234);
        check("pin_errs", {30'd0, model_err(OP_SH, 32'h3), model_err(OP_LW, 32'h0)}, 32'd3);

        // Reset state
        #3;
        check("rst_busy",  32'(st_busy), 32'd0);
        check("rst_done",  32'(st_done), 32'd0);
        check("rst_err",   32'(st_err),  32'd0);
        check("rst_req",   32'(mem_req), 32'd0);
        check("rst_we",    32'(mem_we),  32'd0);
        check("rst_addr",  mem_addr,     32'd0);
        check("rst_wdata", mem_wdata,    32'd0);
        #9 reset = 1'b0;

        run_store(OP_SW,  32'h100, 32'h11223344, 32'h0,        0, 0, 1'b0);
        run_store(OP_SB,  32'h203, 32'h000000AB, 32'hFFFFFFFF, 0, 0, 1'b0);
        run_store(OP_SWL, 32'h1,   32'hA1B2C3D4, 32'h55667788, 0, 0, 1'b0);
        run_store(OP_SWR, 32'h1,   32'hA1B2C3D4, 32'h55667788, 0, 0, 1'b0);
        run_store(OP_SH,  32'h3,   32'h00001234, 32'h0,        0, 0, 1'b0);
        run_store(OP_LW,  32'h40,  32'h12345678, 32'h0,        0, 0, 1'b0);
        run_store(OP_SW,  32'h102, 32'hDEADBEEF, 32'h0,        0, 0, 1'b1);
        run_store(OP_SW,  32'h104, 32'hCAFEF00D, 32'h0,        0, TMO, 1'b0);
        run_store(OP_SW,  32'h108, 32'h0BADF00D, 32'h0,        0, TMO - 1, 1'b0);
        run_store(OP_SH,  32'h2,   32'h00001234, 32'hAABBCCDD, 2, 1, 1'b1);
        run_store(OP_SB,  32'h301, 32'h0000005A, 32'h01020304, TMO, 0, 1'b0);
        run_store(OP_SB,  32'h300, 32'h000000C3, 32'h01020304, TMO - 1, TMO - 1, 1'b1);
        run_store(OP_SWL, 32'h400, 32'h89ABCDEF, 32'h11111111, 1, 0, 1'b1);
        run_store(OP_SWR, 32'h403, 32'h89ABCDEF, 32'h11111111, 0, 2, 1'b0);
        run_store(OP_SWL, 32'h403, 32'h89ABCDEF, 32'h11111111, 0, 0, 1'b0);
        run_store(OP_SWR, 32'h400, 32'h89ABCDEF, 32'h11111111, 0, 0, 1'b1);

        // Reset in the middle of a read.
        @(posedge clk); #1;
        st_req = 1'b1; st_op = OP_SB; st_addr = 32'h540; st_data = 32'h77;
        mem_ack = 1'b0;
        exp_q.push_back(mk(0, 0, 0, 0, 0, 0, 0, 0));
        cyc(mk(1, 0, 0, 1, 0, 0, 32'h540, 0), 1'b0, 32'd0, 1'b0);
        @(negedge clk); #2;
        reset = 1'b1;
        #1;
        check("mid_rst_req",  32'(mem_req), 32'd0);
        check("mid_rst_busy", 32'(st_busy), 32'd0);
        check("mid_rst_done", 32'(st_done), 32'd0);
        @(negedge clk);
        check("held_rst_done", 32'(st_done), 32'd0);
        #1 reset = 1'b0;

        run_store(OP_SB, 32'h541, 32'h00000099, 32'hA0B0C0D0, 1, 0, 1'b1);
        run_store(OP_SH, 32'h540, 32'h0000BEEF, 32'hA0B0C0D0, 0, 0, 1'b0);

        @(negedge clk); #1;
        check("queue_drained", 32'(exp_q.size()), 32'd0);
        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

    // Hard stop in case the flow ever stalls.
    initial begin
        #200000;
        $display("FAIL watchdog: got timeout expected completion");
        n_fail++;
        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $fatal(1, "watchdog");
    end

endmodule
